// File: rtl/fetch_queue.sv
// Prefetching fetch stage: fetches sequential instructions from ROM into a FIFO
// of {instruction, PC} pairs for decode. Optional FETCH_QUEUE_PERF_EN adds stall/flush counters.
module fetch_queue #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_STEP = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirectPc,
    output logic                   triggerOutM,
    output logic [ADDR_W-1:0]      addrOutM,
    input  logic                   readyInM,
    input  logic [DATA_W-1:0]      dataInM,
    output logic                   readyOut,
    output logic [DATA_W-1:0]      dataOut,
    output logic [ADDR_W-1:0]      pcOut,
    input  logic                   triggerIn,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]            stallCnt,
    output logic [15:0]            flushCnt,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    function automatic logic [ADDR_W-1:0] pc_step(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(ADDR_STEP);
    endfunction

    state_t            state_p1, state_p0;
    logic [ADDR_W-1:0] fetch_pc_p1, fetch_pc_p0;
    logic [ADDR_W-1:0] req_addr_p1, req_addr_p0;
    logic              discard_p1, discard_p0;
    logic [CNT_W-1:0]  count_p1, count_p0;
    logic [PTR_W-1:0]  wr_ptr_p1, rd_ptr_p1;
    logic              vld_p1;
    logic              ack_p0, push_p0, pop_p0;

    logic [DATA_W-1:0] mem_data_p1 [DEPTH];
    logic [ADDR_W-1:0] mem_pc_p1   [DEPTH];

    assign vld_p1 = (count_p1 != '0);

    // Stage 0: handshake decode, occupancy and fetch-state next values
    always_comb begin
        ack_p0      = (state_p1 == REQ) && readyInM;
        push_p0     = ack_p0 && !discard_p1 && !redirect;
        pop_p0      = vld_p1 && triggerIn && !redirect;
        count_p0    = redirect ? '0 : count_p1 + CNT_W'(push_p0) - CNT_W'(pop_p0);
        fetch_pc_p0 = fetch_pc_p1;
        discard_p0  = discard_p1;
        req_addr_p0 = req_addr_p1;
        state_p0    = state_p1;

        // A dropped response must not advance the PC: it already points at the redirect target.
        if (ack_p0) begin
            if (!discard_p1) begin
                fetch_pc_p0 = pc_step(fetch_pc_p1);
            end
            discard_p0 = 1'b0;
        end

        // An outstanding ROM request cannot be withdrawn, so its response is marked for dropping.
        if (redirect) begin
            fetch_pc_p0 = redirectPc;
            if ((state_p1 == REQ) && !readyInM) begin
                discard_p0 = 1'b1;
            end
        end

        // The in-flight request already owns a slot, so a new one needs count_p0 < DEPTH.
        case (state_p1)
            IDLE: begin
                if (count_p0 < DEPTH_C) begin
                    state_p0    = REQ;
                    req_addr_p0 = fetch_pc_p0;
                end
            end
            REQ: begin
                if (readyInM) begin
                    if (count_p0 < DEPTH_C) begin
                        state_p0    = REQ;
                        req_addr_p0 = fetch_pc_p0;
                    end else begin
                        state_p0 = IDLE;
                    end
                end
            end
            default: state_p0 = IDLE;
        endcase
    end

    // Stage 1: registered control state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1    <= IDLE;
            fetch_pc_p1 <= RESET_PC;
            req_addr_p1 <= RESET_PC;
            discard_p1  <= 1'b0;
            count_p1    <= '0;
            wr_ptr_p1   <= '0;
            rd_ptr_p1   <= '0;
        end else begin
            state_p1    <= state_p0;
            fetch_pc_p1 <= fetch_pc_p0;
            req_addr_p1 <= req_addr_p0;
            discard_p1  <= discard_p0;
            count_p1    <= count_p0;
            if (redirect) begin
                wr_ptr_p1 <= '0;
                rd_ptr_p1 <= '0;
            end else begin
                if (push_p0) begin
                    wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
                end
                if (pop_p0) begin
                    rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) begin
            mem_data_p1[wr_ptr_p1] <= dataInM;
            mem_pc_p1[wr_ptr_p1]   <= req_addr_p1;
        end
    end

    assign triggerOutM = (state_p1 == REQ);
    assign addrOutM    = req_addr_p1;
    assign readyOut    = vld_p1;
    assign dataOut     = mem_data_p1[rd_ptr_p1];
    assign pcOut       = mem_pc_p1[rd_ptr_p1];
    assign count       = count_p1;

`ifdef FETCH_QUEUE_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!vld_p1 && triggerIn) begin
                stallCnt <= sat_inc32(stallCnt);
            end
            if (redirect) begin
                flushCnt <= sat_inc16(flushCnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stream-level reference of expected PCs, a
// latency-programmable ROM model, and a request-side address model.
module tb_fetch_queue;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4;
    localparam int          STEP  = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

    logic          clk;
    logic          reset;
    logic          redirect;
    logic [AW-1:0] redirectPc;
    logic          triggerOutM;
    logic [AW-1:0] addrOutM;
    logic          readyInM;
    logic [DW-1:0] dataInM;
    logic          readyOut;
    logic [DW-1:0] dataOut;
    logic [AW-1:0] pcOut;
    logic          triggerIn;
    logic [2:0]    count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]   stallCnt;
    logic [15:0]   flushCnt;
    bit            perf_req = 0;
`endif

    fetch_queue #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ADDR_STEP(STEP), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirectPc(redirectPc),
        .triggerOutM(triggerOutM), .addrOutM(addrOutM), .readyInM(readyInM),
        .dataInM(dataInM), .readyOut(readyOut), .dataOut(dataOut), .pcOut(pcOut),
        .triggerIn(triggerIn),
`ifdef FETCH_QUEUE_PERF_EN
        .stallCnt(stallCnt), .flushCnt(flushCnt),
`endif
        .count(count)
    );

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];
    int          pops = 0;
    int          rom_lat = 0;
    bit          spurious_en = 0;
    int          stall_m = 0;
    int          flush_m = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Expected decode stream: every instruction popped after a (re)start is sequential from it.
    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(pc + 32'(i * STEP));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect   = 1'b1;
        redirectPc = pc;
        sb_restart(pc);
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        sb_restart(RPC);
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(readyOut), 32'd0);
        chk("rst_trigger", 32'(triggerOutM), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst_stallcnt", stallCnt, 32'd0);
        chk("rst_flushcnt", 32'(flushCnt), 32'd0);
`endif
        reset = 1'b0;
    endtask

    // ROM model: acks after rom_lat waiting cycles, optionally raises stray acks when idle.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        readyInM = 1'b0;
        dataInM  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                readyInM = 1'b0;
                wait_cnt = 0;
            end else if (triggerOutM) begin
                if (wait_cnt >= rom_lat) begin
                    readyInM = 1'b1;
                    dataInM  = rom_f(addrOutM);
                    wait_cnt = 0;
                end else begin
                    readyInM = 1'b0;
                    dataInM  = $urandom;
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                readyInM = spurious_en && ($urandom_range(0, 7) == 0);
                dataInM  = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted head and tracks the ROM address stream.
    initial begin
        logic [31:0] req_exp, cur_addr, e;
        bit          new_req, stale;
        req_exp = RPC; cur_addr = '0; new_req = 1; stale = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                req_exp = RPC; new_req = 1; stale = 0;
                stall_m = 0; flush_m = 0;
            end else begin
`ifdef FETCH_QUEUE_PERF_EN
                if (perf_req) begin
                    chk("perf_stallcnt", stallCnt, 32'(stall_m));
                    chk("perf_flushcnt", 32'(flushCnt), 32'(flush_m));
                    perf_req = 0;
                end
`endif
                chk("count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
                chk("ready_vs_count", 32'(readyOut), 32'(count != 3'd0));
                if (readyOut && triggerIn && !redirect) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_pc", pcOut, e);
                        chk("pop_data", dataOut, rom_f(e));
                    end
                    pops++;
                end
                if (triggerOutM) begin
                    if (new_req) begin
                        cur_addr = addrOutM;
                        stale    = 0;
                        chk("req_addr", addrOutM, req_exp);
                    end else begin
                        chk("req_hold", addrOutM, cur_addr);
                    end
                    if (readyInM) begin
                        if (!stale) req_exp = req_exp + STEP;
                        new_req = 1;
                    end else begin
                        new_req = 0;
                    end
                end else begin
                    new_req = 1;
                end
                if (redirect) begin
                    req_exp = redirectPc;
                    if (triggerOutM && !readyInM) stale = 1;
                    flush_m++;
                end
                if (!readyOut && triggerIn) stall_m++;
            end
        end
    end

    initial begin
        bit found;
        int start_pops;
        reset = 1'b1; redirect = 1'b0; redirectPc = '0; triggerIn = 1'b0;
        sb_restart(RPC);
        cyc(2);
        chk("init_count", 32'(count), 32'd0);
        chk("init_ready", 32'(readyOut), 32'd0);
        chk("init_trigger", 32'(triggerOutM), 32'd0);
        reset = 1'b0;
        cyc(1);
        chk("first_trigger", 32'(triggerOutM), 32'd1);
        chk("first_addr", addrOutM, RPC);

        // Fill with decode stalled: exactly DEPTH fetches, then the ROM goes quiet.
        cyc(10);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_trigger", 32'(triggerOutM), 32'd0);
        chk("fill_pcout", pcOut, RPC);
        chk("fill_data", dataOut, rom_f(RPC));

        // Continuous decode with 1-cycle ROM: one pop per cycle through the address wrap.
        triggerIn  = 1'b1;
        start_pops = pops;
        cyc(40);
        chk("throughput_pops", 32'(pops - start_pops), 32'd40);

        // Redirect coincident with pop and ROM ack at count=2.
        triggerIn = 1'b0;
        do_redirect(32'h0000_2000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (count == 3'd2 && triggerOutM) found = 1;
        end
        chk("coincide_setup", 32'(found), 32'd1);
        triggerIn = 1'b1;
        do_redirect(32'h0000_3000);
        chk("coincide_count", 32'(count), 32'd0);
        chk("coincide_ready", 32'(readyOut), 32'd0);
        chk("coincide_trigger", 32'(triggerOutM), 32'd1);
        chk("coincide_addr", addrOutM, 32'h0000_3000);
        cyc(10);

        // Slow ROM, redirect mid-wait: old address held, its data dropped.
        rom_lat = 5;
        apply_reset();
        cyc(3);
        chk("slow_trigger", 32'(triggerOutM), 32'd1);
        chk("slow_addr", addrOutM, RPC);
        do_redirect(32'h0000_0100);
        chk("slow_flush_count", 32'(count), 32'd0);
        chk("slow_hold_trigger", 32'(triggerOutM), 32'd1);
        chk("slow_hold_addr", addrOutM, RPC);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (readyOut) found = 1;
            else @(negedge clk);
        end
        chk("slow_first_visible", 32'(found), 32'd1);
        if (found) chk("slow_first_pc", pcOut, 32'h0000_0100);
        cyc(5);

        // Randomised traffic: variable ROM latency, stray acks, random decode and redirects.
        spurious_en = 1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 64 == 0) rom_lat = $urandom_range(0, 3);
            if ((i / 128) % 2 == 0) triggerIn = ($urandom_range(0, 3) != 0);
            else                    triggerIn = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) do_redirect($urandom & 32'hFFFF_FFFC);
            else @(negedge clk);
        end
        spurious_en = 0;
        triggerIn   = 1'b0;
        cyc(2);

`ifdef FETCH_QUEUE_PERF_EN
        perf_req = 1;
        cyc(2);
        rom_lat = 20;
        apply_reset();
        triggerIn = 1'b1;
        cyc(3);
        triggerIn = 1'b0;
        do_redirect(32'h0000_0040);
        do_redirect(32'h0000_0080);
        chk("perf_stall3", stallCnt, 32'd3);
        chk("perf_flush2", 32'(flushCnt), 32'd2);
        rom_lat = 0;
`endif

        cyc(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
